// File: rtl/chan_param_loader_pkg.sv
// Shared types and helpers for the channel parameter loader.
// Optional checksum word is enabled by CHAN_PARAM_CHECKSUM_EN.
package chan_param_loader_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_PAYLOAD,
    S_CSUM,
    S_CHECK,
    S_COMMIT,
    S_DONE
  } state_t;

  localparam logic [31:0] DEF_SYNC_WORD = 32'hFF00_AAAA;
  localparam int CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/chan_param_shadow_ram.sv
// One-frame shadow buffer: write port fed while receiving,
// asynchronous read port drained while committing.
module chan_param_shadow_ram #(
  parameter int DEPTH  = 24,
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/chan_param_loader.sv
// Frame-to-channel parameter loader with atomic commit.
// Define CHAN_PARAM_CHECKSUM_EN to require a trailing sum word.
module chan_param_loader
  import chan_param_loader_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int PARAMS_PER_CH = 3,
  parameter int DATA_W        = 32,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(DEF_SYNC_WORD),
  parameter int TIMEOUT       = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             busy,
  output logic                             cfg_we,
  output logic [idx_w(NUM_CH)-1:0]         cfg_ch,
  output logic [idx_w(PARAMS_PER_CH)-1:0]  cfg_idx,
  output logic [DATA_W-1:0]                cfg_data,
  output logic                             commit_done,
  output logic [CNT_W-1:0]                 frame_ok_cnt,
  output logic [CNT_W-1:0]                 frame_err_cnt,
  output logic [CNT_W-1:0]                 drop_cnt
);

  localparam int FRAME_LEN = NUM_CH * PARAMS_PER_CH;
  localparam int CH_W  = idx_w(NUM_CH);
  localparam int IX_W  = idx_w(PARAMS_PER_CH);
  localparam int PTR_W = idx_w(FRAME_LEN);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME_LEN - 1);
  localparam logic [IX_W-1:0]  IX_LAST  = IX_W'(PARAMS_PER_CH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CH_W-1:0]   rch_q, rch_d;
  logic [IX_W-1:0]   rix_q, rix_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              cfg_we_q, cfg_we_d;
  logic [CH_W-1:0]   cfg_ch_q, cfg_ch_d;
  logic [IX_W-1:0]   cfg_idx_q, cfg_idx_d;
  logic [DATA_W-1:0] cfg_data_q, cfg_data_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  ok_q, ok_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              shw_we;
  logic [DATA_W-1:0] rd_data;
`ifdef CHAN_PARAM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  chan_param_shadow_ram #(
    .DEPTH  (FRAME_LEN),
    .DATA_W (DATA_W),
    .AW     (PTR_W)
  ) u_shadow (
    .clk     (clk),
    .we_i    (shw_we),
    .waddr_i (wptr_q),
    .wdata_i (in_data),
    .raddr_i (rptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rch_d      = rch_q;
    rix_d      = rix_q;
    timer_d    = timer_q;
    cfg_we_d   = 1'b0;
    cfg_ch_d   = cfg_ch_q;
    cfg_idx_d  = cfg_idx_q;
    cfg_data_d = cfg_data_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    err_d      = err_q;
    drop_d     = drop_q;
    shw_we     = 1'b0;
`ifdef CHAN_PARAM_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    unique case (state_q)
      S_HUNT: begin
        if (in_valid && in_data == SYNC_WORD) begin
          state_d = S_PAYLOAD;
          wptr_d  = '0;
          timer_d = '0;
`ifdef CHAN_PARAM_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_PAYLOAD: begin
        if (in_valid) begin
          shw_we  = 1'b1;
          timer_d = '0;
          wptr_d  = wptr_q + 1'b1;
`ifdef CHAN_PARAM_CHECKSUM_EN
          sum_d   = sum_q + in_data;
          if (wptr_q == PTR_LAST) state_d = S_CSUM;
`else
          if (wptr_q == PTR_LAST) state_d = S_CHECK;
`endif
        end else if (timer_q == TMR_LAST) begin
          err_d   = sat_inc(err_q);
          timer_d = '0;
          state_d = S_HUNT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef CHAN_PARAM_CHECKSUM_EN
      S_CSUM: begin
        if (in_valid) begin
          timer_d = '0;
          if (in_data == sum_q) begin
            state_d = S_CHECK;
          end else begin
            err_d   = sat_inc(err_q);
            state_d = S_HUNT;
          end
        end else if (timer_q == TMR_LAST) begin
          err_d   = sat_inc(err_q);
          timer_d = '0;
          state_d = S_HUNT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      S_CHECK: begin
        rptr_d  = '0;
        rch_d   = '0;
        rix_d   = '0;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        cfg_we_d   = 1'b1;
        cfg_ch_d   = rch_q;
        cfg_idx_d  = rix_q;
        cfg_data_d = rd_data;
        rptr_d     = rptr_q + 1'b1;
        // Channel/index counters avoid a divider on rptr.
        if (rix_q == IX_LAST) begin
          rix_d = '0;
          rch_d = rch_q + 1'b1;
        end else begin
          rix_d = rix_q + 1'b1;
        end
        if (rptr_q == PTR_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        ok_d    = sat_inc(ok_q);
        state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase
    if (in_valid && (state_q == S_CHECK || state_q == S_COMMIT ||
                     state_q == S_DONE)) begin
      drop_d = sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HUNT;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rch_q      <= '0;
      rix_q      <= '0;
      timer_q    <= '0;
      cfg_we_q   <= 1'b0;
      cfg_ch_q   <= '0;
      cfg_idx_q  <= '0;
      cfg_data_q <= '0;
      done_q     <= 1'b0;
      ok_q       <= '0;
      err_q      <= '0;
      drop_q     <= '0;
`ifdef CHAN_PARAM_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rch_q      <= rch_d;
      rix_q      <= rix_d;
      timer_q    <= timer_d;
      cfg_we_q   <= cfg_we_d;
      cfg_ch_q   <= cfg_ch_d;
      cfg_idx_q  <= cfg_idx_d;
      cfg_data_q <= cfg_data_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
`ifdef CHAN_PARAM_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign busy          = (state_q == S_CHECK) || (state_q == S_COMMIT);
  assign cfg_we        = cfg_we_q;
  assign cfg_ch        = cfg_ch_q;
  assign cfg_idx       = cfg_idx_q;
  assign cfg_data      = cfg_data_q;
  assign commit_done   = done_q;
  assign frame_ok_cnt  = ok_q;
  assign frame_err_cnt = err_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_chan_param_loader.sv
// Directed and randomized frames against a frame-level model.
// Exercises CHAN_PARAM_CHECKSUM_EN when the macro is defined.
module tb_chan_param_loader;

  localparam int NCH = 8;
  localparam int PPC = 3;
  localparam int FL  = NCH * PPC;
  localparam int TO  = 1024;
  localparam logic [31:0] SYNC = 32'hFF00_AAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        busy, cfg_we, commit_done;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_data;
  logic [15:0] frame_ok_cnt, frame_err_cnt, drop_cnt;

  chan_param_loader #(
    .NUM_CH(NCH), .PARAMS_PER_CH(PPC), .DATA_W(32),
    .SYNC_WORD(SYNC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .commit_done(commit_done),
    .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  logic [47:0] wr_q[$];
  int done_cnt = 0;
  int first_we_tick, last_we_tick, done_tick;

  always @(negedge clk) begin
    if (cfg_we) begin
      if (wr_q.size() == 0) first_we_tick = tick;
      last_we_tick = tick;
      wr_q.push_back({5'd0, cfg_ch, 6'd0, cfg_idx, cfg_data});
    end
    if (commit_done) begin
      done_cnt++;
      done_tick = tick;
    end
  end

  int nchk = 0;
  int nerr = 0;
  int ok_exp = 0, err_exp = 0, drop_exp = 0;
  int last_acc;
  logic [31:0] frm [FL];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit bad, input int gap_max,
                            input int stall_at, input int stall_len);
    logic [31:0] s;
    s = '0;
    cyc(1'b1, SYNC);
    for (int k = 0; k < FL; k++) begin
      cyc(1'b1, frm[k]);
      last_acc = tick;
      s = s + frm[k];
      if (k == stall_at) begin
        repeat (stall_len) cyc(1'b0, $urandom);
        if (stall_len >= TO) return;
      end else if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) cyc(1'b0, $urandom);
      end
    end
`ifdef CHAN_PARAM_CHECKSUM_EN
    cyc(1'b1, bad ? s + 32'd1 : s);
    last_acc = tick;
`endif
  endtask

  task automatic check_frame(input string tag, input bit exp_ok,
                             input int done0);
    logic [47:0] e;
    repeat (FL + 8) cyc(1'b0, 32'd0);
    if (exp_ok) ok_exp++;
    chk({tag, "_nwr"}, wr_q.size(), exp_ok ? FL : 0);
    for (int k = 0; k < FL && k < wr_q.size(); k++) begin
      e = {5'd0, 3'(k / PPC), 6'd0, 2'(k % PPC), frm[k]};
      chk({tag, "_wr"}, wr_q[k], e);
    end
    chk({tag, "_done"}, done_cnt - done0, exp_ok ? 1 : 0);
    chk({tag, "_ok"}, frame_ok_cnt, ok_exp);
    chk({tag, "_err"}, frame_err_cnt, err_exp);
    chk({tag, "_drop"}, drop_cnt, drop_exp);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < FL; k++) frm[k] = $urandom;
  endtask

  initial begin
    int d0;
    bit bad;
    logic [31:0] g;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", cfg_we, 0);
    chk("rst_ch", cfg_ch, 0);
    chk("rst_idx", cfg_idx, 0);
    chk("rst_data", cfg_data, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_cnt", {frame_ok_cnt, frame_err_cnt, drop_cnt}, 0);
    rst = 1'b0;
    cyc(1'b0, 32'd0);

    // Directed frame 0..23 (checksum 276 when enabled)
    for (int k = 0; k < FL; k++) frm[k] = k;
    wr_q.delete(); d0 = done_cnt;
    send_frame(1'b0, 0, -1, 0);
    check_frame("seq", 1'b1, d0);
    chk("w5", wr_q[5], {5'd0, 3'd1, 6'd0, 2'd2, 32'd5});
    chk("lat", first_we_tick - last_acc, 2);
    chk("we_run", last_we_tick - first_we_tick, FL - 1);
    chk("done_lat", done_tick - last_we_tick, 1);

`ifdef CHAN_PARAM_CHECKSUM_EN
    wr_q.delete(); d0 = done_cnt;
    send_frame(1'b1, 0, -1, 0);
    err_exp++;
    check_frame("badsum", 1'b0, d0);
    rand_frame();
    wr_q.delete(); d0 = done_cnt;
    send_frame(1'b0, 0, -1, 0);
    check_frame("aftbad", 1'b1, d0);
`endif

    // Timeout abort after word 10, garbage before SYNC ignored
    cyc(1'b1, 32'h1234);
    rand_frame();
    wr_q.delete(); d0 = done_cnt;
    send_frame(1'b0, 0, 10, TO);
    err_exp++;
    check_frame("tmo", 1'b0, d0);

    // Idle one cycle short of the timeout does not abort
    cyc(1'b1, 32'h1234);
    rand_frame();
    frm[3] = SYNC;
    wr_q.delete(); d0 = done_cnt;
    send_frame(1'b0, 0, 10, TO - 1);
    check_frame("notmo", 1'b1, d0);

    // Words offered during commit are dropped
    rand_frame();
    wr_q.delete(); d0 = done_cnt;
    send_frame(1'b0, 0, -1, 0);
    for (int i = 0; i < 10 && !cfg_we; i++) cyc(1'b0, 32'd0);
    chk("drop_we_on", cfg_we, 1);
    chk("drop_busy", busy, 1);
    cyc(1'b1, SYNC);
    cyc(1'b1, $urandom);
    cyc(1'b1, $urandom);
    drop_exp += 3;
    check_frame("drop", 1'b1, d0);

    // Reset on the 7th commit cycle
    rand_frame();
    wr_q.delete(); d0 = done_cnt;
    send_frame(1'b0, 0, -1, 0);
    for (int i = 0; i < 10 && !cfg_we; i++) cyc(1'b0, 32'd0);
    chk("mrst_we_on", cfg_we, 1);
    repeat (6) cyc(1'b0, 32'd0);
    rst = 1'b1;
    cyc(1'b0, 32'd0);
    chk("mrst_we", cfg_we, 0);
    chk("mrst_out", {busy, commit_done, cfg_ch, cfg_idx, cfg_data}, 0);
    chk("mrst_cnt", {frame_ok_cnt, frame_err_cnt, drop_cnt}, 0);
    rst = 1'b0;
    ok_exp = 0; err_exp = 0; drop_exp = 0;
    repeat (FL + 8) cyc(1'b0, 32'd0);
    chk("mrst_nwr", wr_q.size(), 7);
    chk("mrst_nodone", done_cnt - d0, 0);

    // Randomized frames with gaps, garbage and bad checksums
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(3, 0)) begin
        g = $urandom;
        if (g == SYNC) g = 32'd0;
        cyc(1'b1, g);
      end
      rand_frame();
      if ($urandom_range(3, 0) == 0) frm[$urandom_range(FL - 1, 0)] = SYNC;
`ifdef CHAN_PARAM_CHECKSUM_EN
      bad = ($urandom_range(3, 0) == 0);
`else
      bad = 1'b0;
`endif
      if (bad) err_exp++;
      wr_q.delete(); d0 = done_cnt;
      send_frame(bad, 3, -1, 0);
      check_frame("rnd", !bad, d0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
